// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the feature-map writer state encoding.
package cnn_pkg;

  localparam int IMG_W       = 26;
  localparam int IMG_H       = 26;
  localparam int FRAME_PIX   = IMG_W * IMG_H;
  localparam int PIX_W       = 16;
  localparam int FMAP_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    FULL  = 2'd3
  } fmw_state_t;

endpackage

// File: rtl/fmap_addr_counter.sv
// Raster row/col/linear-pointer walker built from incrementers only.
// Shared by the writer and the pool stage's read-address generator.
module fmap_addr_counter
  import cnn_pkg::*;
#(
  parameter int IMG_W  = cnn_pkg::IMG_W,
  parameter int IMG_H  = cnn_pkg::IMG_H,
  parameter int ADDR_W = cnn_pkg::FMAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [7:0]        row,
  output logic [7:0]        col,
  output logic [ADDR_W-1:0] ptr,
  output logic              last
);

  localparam logic [7:0]        COL_MAX = 8'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(IMG_W * IMG_H - 1);

  logic [7:0]        row_r;
  logic [7:0]        col_r;
  logic [ADDR_W-1:0] ptr_r;

  assign row  = row_r;
  assign col  = col_r;
  assign ptr  = ptr_r;
  assign last = (ptr_r == PTR_MAX);

  // Advance one pixel per enable; the final pixel wraps everything back to the origin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_r <= 8'd0;
      col_r <= 8'd0;
      ptr_r <= '0;
    end else if (clr) begin
      row_r <= 8'd0;
      col_r <= 8'd0;
      ptr_r <= '0;
    end else if (en) begin
      if (last) begin
        row_r <= 8'd0;
        col_r <= 8'd0;
        ptr_r <= '0;
      end else begin
        ptr_r <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (col_r == COL_MAX) begin
          col_r <= 8'd0;
          row_r <= row_r + 8'd1;
        end else begin
          col_r <= col_r + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/fmap_writer.sv
// Writes a raster pixel stream into the feature-map RAM and holds the finished
// frame (frame_ready) until the pool stage releases it.
module fmap_writer
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::PIX_W,
  parameter int IMG_W  = cnn_pkg::IMG_W,
  parameter int IMG_H  = cnn_pkg::IMG_H,
  parameter int ADDR_W = cnn_pkg::FMAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              frame_ready,
  input  logic              frame_release,
  output logic [7:0]        row,
  output logic [7:0]        col,
  output logic              err_last
);

  fmw_state_t        state_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              frame_ready_r;
  logic              err_last_r;

  logic              accept_s;
  logic              last_s;
  logic              clr_s;
  logic [ADDR_W-1:0] wr_ptr_s;

  // Ready depends on state alone so the producer never sees a valid->ready loop.
  assign in_ready = (state_r == IDLE) || (state_r == FILL);
  assign accept_s = in_valid & in_ready;
  assign clr_s    = (state_r == FULL) & frame_release;

  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign frame_ready = frame_ready_r;
  assign err_last    = err_last_r;

  fmap_addr_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk  (clk),
    .rst  (rst),
    .en   (accept_s),
    .clr  (clr_s),
    .row  (row),
    .col  (col),
    .ptr  (wr_ptr_s),
    .last (last_s)
  );

  // Frame-level FSM plus the registered RAM write port and sticky in_last check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= '0;
      mem_wdata_r   <= '0;
      frame_ready_r <= 1'b0;
      err_last_r    <= 1'b0;
    end else begin
      mem_we_r <= accept_s;
      if (accept_s) begin
        mem_addr_r  <= wr_ptr_s;
        mem_wdata_r <= in_data;
        if (in_last != last_s) begin
          err_last_r <= 1'b1;
        end
      end

      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r <= last_s ? DRAIN : FILL;
          end
        end
        FILL: begin
          if (accept_s && last_s) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          state_r       <= FULL;
          frame_ready_r <= 1'b1;
        end
        FULL: begin
          if (frame_release) begin
            state_r       <= IDLE;
            frame_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          frame_ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_writer.sv
// Directed self-checking bench for fmap_writer: full frames, hold/release,
// gapped input, in_last errors, mid-frame reset and stray releases.
module tb_fmap_writer;

  localparam int NPIX = 676;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        frame_ready;
  logic        frame_release;
  logic [7:0]  row;
  logic [7:0]  col;
  logic        err_last;

  int          n_checks;
  int          n_fail;
  int          n_wr;
  int          exp_addr;
  logic [5:0]  cur_tag;

  fmap_writer dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .frame_ready   (frame_ready),
    .frame_release (frame_release),
    .row           (row),
    .col           (col),
    .err_last      (err_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every RAM write must land at the next raster address with data {tag, addr}.
  always @(negedge clk) begin
    if (rst) begin
      exp_addr = 0;
    end else if (mem_we) begin
      check("wr_addr", 32'(mem_addr), 32'(exp_addr));
      check("wr_data", 32'(mem_wdata), 32'({cur_tag, exp_addr[9:0]}));
      n_wr++;
      exp_addr = (exp_addr == NPIX - 1) ? 0 : exp_addr + 1;
    end
  end

  // Streams npix pixels starting from posedge+1; returns at posedge+1.
  task automatic send_frame(input logic [5:0] tag, input int gap_pct, input int bad_idx,
                            input bit omit_last, input int npix, input bit hold_rel);
    bit acc;
    int cyc;
    int fr_hi;
    n_wr          = 0;
    cur_tag       = tag;
    fr_hi         = 0;
    frame_release = hold_rel;
    for (int i = 0; i < npix; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        fr_hi += int'(frame_ready);
      end
      if (i == 27) begin
        check("row_at_27", 32'(row), 32'd1);
        check("col_at_27", 32'(col), 32'd1);
      end
      if (i == bad_idx) check("err_before_bad", 32'(err_last), 32'd0);
      in_valid = 1'b1;
      in_data  = {tag, 10'(i)};
      in_last  = (i == NPIX - 1) ? !omit_last : (i == bad_idx);
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 20) begin
        acc = in_ready;
        @(posedge clk); #1;
        fr_hi += int'(frame_ready);
        cyc++;
      end
      if (!acc) begin
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      if (i == bad_idx) check("err_after_bad", 32'(err_last), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (npix == NPIX) begin
      check("drain_in_ready", 32'(in_ready), 32'd0);
      check("drain_we", 32'(mem_we), 32'd1);
      check("drain_addr", 32'(mem_addr), 32'd675);
      check("drain_frame_ready", 32'(frame_ready), 32'd0);
      check("fill_frame_ready_cycles", 32'(fr_hi), 32'd0);
      @(posedge clk); #1;
      frame_release = 1'b0;
      check("full_frame_ready", 32'(frame_ready), 32'd1);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("frame_writes", 32'(n_wr), 32'(NPIX));
    end
  endtask

  task automatic release_frame();
    frame_release = 1'b1;
    @(posedge clk); #1;
    frame_release = 1'b0;
    check("rel_frame_ready", 32'(frame_ready), 32'd0);
    check("rel_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int w0;
    int rdy_hi;
    n_checks      = 0;
    n_fail        = 0;
    n_wr          = 0;
    exp_addr      = 0;
    cur_tag       = 6'd0;
    rst           = 1'b1;
    in_data       = 16'd0;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    frame_release = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_frame_ready", 32'(frame_ready), 32'd0);
    check("rst_err", 32'(err_last), 32'd0);
    check("rst_row", 32'(row), 32'd0);
    check("rst_col", 32'(col), 32'd0);

    // 1: back-to-back full frame
    send_frame(6'd1, 0, -1, 1'b0, NPIX, 1'b0);
    check("t1_err", 32'(err_last), 32'd0);

    // 2: producer pushes against a full buffer
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    w0       = n_wr;
    rdy_hi   = 0;
    repeat (50) begin
      @(posedge clk); #1;
      rdy_hi += int'(in_ready);
    end
    check("t2_no_write", 32'(n_wr - w0), 32'd0);
    check("t2_ready_cycles", 32'(rdy_hi), 32'd0);
    check("t2_frame_ready", 32'(frame_ready), 32'd1);
    in_valid = 1'b0;
    release_frame();

    // 3: gapped input, second frame restarts at address 0
    send_frame(6'd2, 30, -1, 1'b0, NPIX, 1'b0);
    check("t3_err", 32'(err_last), 32'd0);
    release_frame();

    // 4: in_last early on pixel 100 and missing on the final pixel
    send_frame(6'd3, 0, 100, 1'b1, NPIX, 1'b0);
    check("t4_err_sticky", 32'(err_last), 32'd1);
    release_frame();
    check("t4_err_after_release", 32'(err_last), 32'd1);

    // 5: asynchronous reset part-way through a frame
    send_frame(6'd4, 0, -1, 1'b0, 300, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_we", 32'(mem_we), 32'd0);
    check("t5_rst_row", 32'(row), 32'd0);
    check("t5_rst_col", 32'(col), 32'd0);
    check("t5_rst_err", 32'(err_last), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_frame_ready", 32'(frame_ready), 32'd0);
    send_frame(6'd5, 0, -1, 1'b0, NPIX, 1'b0);
    check("t5_err", 32'(err_last), 32'd0);
    release_frame();

    // 6: stray releases in IDLE, FILL and DRAIN are ignored
    frame_release = 1'b1;
    @(posedge clk); #1;
    frame_release = 1'b0;
    check("t6_idle_in_ready", 32'(in_ready), 32'd1);
    check("t6_idle_frame_ready", 32'(frame_ready), 32'd0);
    send_frame(6'd6, 0, -1, 1'b0, NPIX, 1'b1);
    @(posedge clk); #1;
    check("t6_still_full", 32'(frame_ready), 32'd1);
    check("t6_still_blocked", 32'(in_ready), 32'd0);
    release_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fmap_writer.md
Name: fmap_writer

Overview:
- Writer side of the feature-map memory that the 2x2/stride-2 max-pool stage reads.
- Accepts a raster-order pixel stream from the convolution stage over a valid/ready handshake.
- Writes each pixel into the single-bank feature-map RAM at row*IMG_W+col.
- Holds the completed frame for the pool stage, asserting frame_ready until released, and backpressures the producer meanwhile.

Parameters:
DATA_W, 16, pixel width
IMG_W, 26, pixels per row
IMG_H, 26, rows per frame
ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_data  in  DATA_W  pixel from conv stage
in_valid  in  1  in_data valid
in_last  in  1  producer marks final pixel of frame
in_ready  out  1  writer can accept a pixel
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM write address
mem_wdata  out  DATA_W  RAM write data
frame_ready  out  1  full frame resident in RAM
frame_release  in  1  pool stage done reading; pulse
row  out  8  row of next pixel to be accepted
col  out  8  column of next pixel to be accepted
err_last  out  1  sticky in_last mismatch flag

Behaviour:
- Reset (async): state IDLE; wr_ptr, row, col = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; frame_ready = 0; err_last = 0; in_ready = 1 once reset is released.
- Handshake: a pixel is accepted on a rising edge with in_valid & in_ready. in_ready = 1 in IDLE and FILL, 0 in DRAIN and FULL. in_ready is combinational from state only, never from in_valid.
- Write latency is 1 cycle. On the edge after acceptance: mem_we = 1, mem_addr = address of that pixel, mem_wdata = the pixel. Otherwise mem_we = 0, and mem_addr/mem_wdata hold their last values.
- Address generation uses incrementers only, no multiplier:
  - col increments; at col == IMG_W-1 it wraps to 0 and row increments.
  - wr_ptr increments by 1 per accepted pixel.
- States:
  - IDLE: wr_ptr = 0. First acceptance -> FILL, or -> DRAIN if IMG_W*IMG_H == 1.
  - FILL: accept pixels. Acceptance at wr_ptr == IMG_W*IMG_H-1 -> DRAIN.
  - DRAIN: exactly one cycle; the last write is on the RAM port. -> FULL, and frame_ready = 1 from the next edge.
  - FULL: frame_ready = 1, no acceptance. frame_release = 1 -> IDLE; frame_ready, wr_ptr, row, col cleared on that edge.
- frame_release outside FULL (including DRAIN) is ignored.
- in_valid with in_ready low is not a transfer; the producer holds its data.
- in_last check on every accepted pixel:
  - in_last = 1 on a non-final pixel -> err_last set.
  - in_last = 0 on the final pixel -> err_last set.
  - The frame still completes on the pixel count; in_last never truncates or extends a frame.
  - err_last is cleared only by rst.
- Reset mid-frame: partial frame abandoned, counters zeroed. RAM contents are undefined to the reader, because frame_ready stays 0.
- Back-to-back frames: after release, IDLE accepts on the very next edge. Minimum frame period is IMG_W*IMG_H + 2 cycles + reader hold time.
- Widths: wr_ptr is ADDR_W bits and never exceeds IMG_W*IMG_H-1. row and col are zero-extended to 8 bits.

Decomposition:
- Shared package cnn_pkg:
  - constants IMG_W, IMG_H, FRAME_PIX = IMG_W*IMG_H, PIX_W = 16, FMAP_ADDR_W = 10;
  - state enum type fmw_state_t {IDLE, FILL, DRAIN, FULL}.
- One sub-module, fmap_addr_counter: row/col/linear-pointer counter with enable, clear, and a last-pixel flag. The pool stage can reuse it for its own read-address walk.

Test Plan:
1. Reset, then stream 676 pixels with data = index, in_valid held high, in_last on pixel 675 -> writes at addr 0..675 with wdata = addr. in_ready drops the cycle after pixel 675 is accepted. frame_ready = 1 two edges after that acceptance. err_last = 0.
2. While FULL, hold in_valid = 1 for 50 cycles -> no mem_we, in_ready = 0. Pulse frame_release -> frame_ready = 0 and in_ready = 1 on the next cycle. Second frame starts at addr 0.
3. Random in_valid gaps (about 30% idle) -> RAM image identical to case 1. At pixel index 27, row = 1 and col = 1.
4. Assert in_last on pixel 100 and omit it on pixel 675 -> err_last rises after pixel 100 and stays 1. Frame still completes at 676 pixels.
5. Assert rst asynchronously after 300 pixels, then stream a full frame -> first post-reset write at addr 0. frame_ready only after 676 new pixels.
6. Pulse frame_release in IDLE, FILL and DRAIN -> no state change and no frame_ready glitch.
